// File: rtl/fp_add_arb.sv
// Round-robin arbiter that shares one combinational IEEE-754 binary32 adder
// among NREQ requesters and registers the sum together with the winner's ID.
// fp_add is the shared adder (round-to-nearest-even, subnormals supported,
// NaN results are returned as the canonical quiet NaN 7FC00000).

module fp_add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    logic        a_nan, b_nan, a_inf, b_inf;
    logic        swap;
    logic        s_l, s_s, op_sub;
    logic [7:0]  e_l, e_s, d;
    logic [23:0] m_l, m_s;
    logic [26:0] ms_x, ms_sh, sh_mask;
    logic        sticky;
    logic [27:0] sum28;
    logic [4:0]  lz;
    logic [7:0]  nsh;
    logic [26:0] n;
    logic [9:0]  e_n, e_f;
    logic        rnd_up;
    logic [24:0] mr;
    logic [22:0] frac_f;

    // Leading-zero count over the 27-bit working mantissa (27 when all zero).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] cnt;
        logic       found;
        cnt   = 5'd27;
        found = 1'b0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (!found && v[26 - i]) begin
                cnt   = 5'(i);
                found = 1'b1;
            end
        end
        return cnt;
    endfunction

    // Align, add/subtract, normalise, round-to-nearest-even, pack.
    always_comb begin
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != '0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != '0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == '0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == '0);

        // Larger magnitude goes to the "l" side; subnormals use exponent 1.
        swap = b[30:0] > a[30:0];
        if (swap) begin
            s_l = b[31];
            s_s = a[31];
            e_l = (b[30:23] == '0) ? 8'd1 : b[30:23];
            e_s = (a[30:23] == '0) ? 8'd1 : a[30:23];
            m_l = {(b[30:23] != '0), b[22:0]};
            m_s = {(a[30:23] != '0), a[22:0]};
        end else begin
            s_l = a[31];
            s_s = b[31];
            e_l = (a[30:23] == '0) ? 8'd1 : a[30:23];
            e_s = (b[30:23] == '0) ? 8'd1 : b[30:23];
            m_l = {(a[30:23] != '0), a[22:0]};
            m_s = {(b[30:23] != '0), b[22:0]};
        end
        op_sub = s_l ^ s_s;
        d      = e_l - e_s;

        // Three extra bits (guard, round, sticky) below the mantissa.
        ms_x    = {m_s, 3'b000};
        sh_mask = '0;
        sticky  = 1'b0;
        if (d >= 8'd27) begin
            ms_sh = {26'b0, |ms_x};
        end else begin
            sh_mask = ~({27{1'b1}} << d);
            sticky  = |(ms_x & sh_mask);
            ms_sh   = (ms_x >> d) | {26'b0, sticky};
        end

        if (op_sub) begin
            sum28 = {1'b0, m_l, 3'b000} - {1'b0, ms_sh};
        end else begin
            sum28 = {1'b0, m_l, 3'b000} + {1'b0, ms_sh};
        end

        // Carry-out shifts right; otherwise shift left, capped so the
        // exponent never drops below 1 (result becomes subnormal instead).
        lz = lzc27(sum28[26:0]);
        if (sum28[27]) begin
            nsh = '0;
            n   = {sum28[27:2], sum28[1] | sum28[0]};
            e_n = {2'b00, e_l} + 10'd1;
        end else begin
            nsh = ({3'b000, lz} < (e_l - 8'd1)) ? {3'b000, lz} : (e_l - 8'd1);
            n   = sum28[26:0] << nsh;
            e_n = {2'b00, e_l} - {2'b00, nsh};
        end

        rnd_up = n[2] & (n[1] | n[0] | n[3]);
        mr     = {1'b0, n[26:3]} + {24'b0, rnd_up};

        // A subnormal that rounds up into the hidden bit gets exponent 1,
        // which e_n already holds because of the shift cap above.
        if (mr[24]) begin
            e_f    = e_n + 10'd1;
            frac_f = mr[23:1];
        end else begin
            e_f    = mr[23] ? e_n : 10'd0;
            frac_f = mr[22:0];
        end

        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
            sum = 32'h7FC0_0000;
        end else if (a_inf) begin
            sum = a;
        end else if (b_inf) begin
            sum = b;
        end else if (sum28 == '0) begin
            sum = {(op_sub ? 1'b0 : s_l), 31'b0};
        end else if (e_f >= 10'd255) begin
            sum = {s_l, 8'hFF, 23'b0};
        end else begin
            sum = {s_l, e_f[7:0], frac_f};
        end
    end

endmodule

module fp_add_arb #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic [ID_W-1:0]      out_id,
    output logic [31:0]          op_count
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W:0]   NREQ_W = (PTR_W + 1)'(NREQ);
    localparam logic [PTR_W-1:0] LAST   = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   scan_sum;
    logic [PTR_W-1:0] scan_idx;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_found;
    logic             can_accept;
    logic             xfer;
    logic [31:0]      sel_a, sel_b, add_sum;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_result_q, out_result_d;
    logic [ID_W-1:0]  out_id_q, out_id_d;
    logic [31:0]      op_count_q, op_count_d;

    assign can_accept = ~out_valid_q | out_ready;

    // Round-robin scan starting at ptr; first valid index wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            scan_sum = {1'b0, ptr_q} + (PTR_W + 1)'(off);
            scan_idx = (scan_sum >= NREQ_W) ? PTR_W'(scan_sum - NREQ_W) : PTR_W'(scan_sum);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    // Operand mux for the granted requester and one-hot ready.
    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == gnt_idx) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
        if (gnt_found && can_accept && rst_n) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer = gnt_found & can_accept & rst_n;

    fp_add u_fp_add (
        .a   (sel_a),
        .b   (sel_b),
        .sum (add_sum)
    );

    // Next-state: transfer loads a new result (even while draining), otherwise drain or hold.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_id_d     = out_id_q;
        op_count_d   = op_count_q;
        ptr_d        = ptr_q;
        if (xfer) begin
            out_valid_d  = 1'b1;
            out_result_d = add_sum;
            out_id_d     = ID_W'(gnt_idx);
            op_count_d   = op_count_q + 32'd1;
            ptr_d        = (gnt_idx == LAST) ? '0 : gnt_idx + PTR_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register, pointer and operation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_id_q     <= '0;
            op_count_q   <= '0;
            ptr_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_id_q     <= out_id_d;
            op_count_q   <= op_count_d;
            ptr_q        <= ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_id     = out_id_q;
    assign op_count   = op_count_q;

endmodule
